// File: rtl/calc_ng_pkg.sv
// calc_ng_pkg: command/response codes and request entry types shared by the
// calc_ng core and its per-channel capture FIFOs.
package calc_ng_pkg;

  typedef logic [3:0] cmd_t;
  typedef logic [1:0] resp_t;

  localparam cmd_t CMD_NOP = 4'd0;
  localparam cmd_t CMD_ADD = 4'd1;
  localparam cmd_t CMD_SUB = 4'd2;
  localparam cmd_t CMD_SHL = 4'd5;
  localparam cmd_t CMD_SHR = 4'd6;

  localparam resp_t RESP_NONE = 2'd0;
  localparam resp_t RESP_OK   = 2'd1;
  localparam resp_t RESP_ERR  = 2'd2;

  localparam int MAX_DATA_W = 64;

  // Widest request entry; each channel FIFO stores the same layout narrowed to DATA_W.
  typedef struct packed {
    cmd_t                  cmd;
    logic [MAX_DATA_W-1:0] op1;
    logic [MAX_DATA_W-1:0] op2;
  } req_entry_t;

  typedef enum logic {
    CAP_IDLE = 1'b0,
    CAP_OP2  = 1'b1
  } cap_state_t;

endpackage

// File: rtl/calc_ng_chan_fifo.sv
// calc_ng_chan_fifo: two-cycle request capture FSM plus request FIFO for one
// channel. busy covers both queued entries and a half-captured request so an
// accepted command always has a slot waiting for its second operand.
module calc_ng_chan_fifo
  import calc_ng_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              c_clk,
  input  logic              reset,
  input  cmd_t              cmd,
  input  logic [DATA_W-1:0] data,
  input  logic              pop,
  output logic              busy,
  output logic              empty,
  output cmd_t              head_cmd,
  output logic [DATA_W-1:0] head_op1,
  output logic [DATA_W-1:0] head_op2
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    cmd_t              cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } entry_t;

  cap_state_t        state, state_nxt;
  cmd_t              cmd_q;
  logic [DATA_W-1:0] op1_q;
  entry_t            mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, occ;
  logic              accept, push;

  assign occ    = count + {{(CNT_W-1){1'b0}}, (state == CAP_OP2)};
  assign busy   = (occ >= CNT_W'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign accept = (state == CAP_IDLE) && (cmd != CMD_NOP) && !busy;
  assign push   = (state == CAP_OP2);

  assign head_cmd = mem[rd_ptr].cmd;
  assign head_op1 = mem[rd_ptr].op1;
  assign head_op2 = mem[rd_ptr].op2;

  // Capture FSM next state: first operand in IDLE, second operand in OP2.
  always_comb begin
    state_nxt = state;
    case (state)
      CAP_IDLE: if (accept) state_nxt = CAP_OP2;
      CAP_OP2:  state_nxt = CAP_IDLE;
      default:  state_nxt = CAP_IDLE;
    endcase
  end

  // Capture FSM state register.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) state <= CAP_IDLE;
    else        state <= state_nxt;
  end

  // Operand latches and FIFO storage; contents are don't-care while empty.
  always_ff @(posedge c_clk) begin
    if (accept) begin
      cmd_q <= cmd;
      op1_q <= data;
    end
    if (push) mem[wr_ptr] <= '{cmd: cmd_q, op1: op1_q, op2: data};
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/calc_ng.sv
// calc_ng: NUM_CH request channels, each with a capture FIFO, sharing one
// combinational ALU behind an arbiter. Define CALC_NG_RR_ARB_EN for
// round-robin arbitration; otherwise fixed priority with channel 0 highest.
module calc_ng
  import calc_ng_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     c_clk,
  input  logic                     reset,
  input  logic [NUM_CH*4-1:0]      req_cmd_in,
  input  logic [NUM_CH*DATA_W-1:0] req_data_in,
  output logic [NUM_CH-1:0]        req_busy,
  output logic [NUM_CH*2-1:0]      out_resp,
  output logic [NUM_CH*DATA_W-1:0] out_data
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef struct packed {
    resp_t             resp;
    logic [DATA_W-1:0] data;
  } alu_res_t;

  // Unsigned ALU; overflow, underflow and unknown commands answer ERR with zero data.
  function automatic alu_res_t alu_eval(input cmd_t cmd, input logic [DATA_W-1:0] a,
                                        input logic [DATA_W-1:0] b);
    alu_res_t          res;
    logic [DATA_W:0]   sum;
    res = '{resp: RESP_ERR, data: '0};
    sum = {1'b0, a} + {1'b0, b};
    case (cmd)
      CMD_ADD: if (!sum[DATA_W]) res = '{resp: RESP_OK, data: sum[DATA_W-1:0]};
      CMD_SUB: if (b <= a) res = '{resp: RESP_OK, data: a - b};
      CMD_SHL: res = '{resp: RESP_OK, data: a << b[SH_W-1:0]};
      CMD_SHR: res = '{resp: RESP_OK, data: a >> b[SH_W-1:0]};
      default: res = '{resp: RESP_ERR, data: '0};
    endcase
    return res;
  endfunction

  logic [NUM_CH-1:0] empty, pop;
  cmd_t              head_cmd [NUM_CH];
  logic [DATA_W-1:0] head_op1 [NUM_CH];
  logic [DATA_W-1:0] head_op2 [NUM_CH];
  resp_t             resp_p1  [NUM_CH];
  logic [DATA_W-1:0] data_p1  [NUM_CH];
  logic              vld_p0;
  logic [CH_W-1:0]   sel_p0;
  alu_res_t          res_p0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    calc_ng_chan_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .c_clk    (c_clk),
      .reset    (reset),
      .cmd      (req_cmd_in[g*4 +: 4]),
      .data     (req_data_in[g*DATA_W +: DATA_W]),
      .pop      (pop[g]),
      .busy     (req_busy[g]),
      .empty    (empty[g]),
      .head_cmd (head_cmd[g]),
      .head_op1 (head_op1[g]),
      .head_op2 (head_op2[g])
    );
    assign out_resp[g*2 +: 2]           = resp_p1[g];
    assign out_data[g*DATA_W +: DATA_W] = data_p1[g];
  end

`ifdef CALC_NG_RR_ARB_EN
  logic [CH_W-1:0] rr_ptr;

  // Round-robin pick: first non-empty channel at or after the pointer.
  always_comb begin
    vld_p0 = 1'b0;
    sel_p0 = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!vld_p0 && !empty[(int'(rr_ptr) + k) % NUM_CH]) begin
        vld_p0 = 1'b1;
        sel_p0 = CH_W'((int'(rr_ptr) + k) % NUM_CH);
      end
    end
  end

  // Pointer advances to the channel after the one just served.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset)      rr_ptr <= '0;
    else if (vld_p0) rr_ptr <= (int'(sel_p0) == NUM_CH - 1) ? '0 : sel_p0 + 1'b1;
  end
`else
  // Fixed-priority pick: lowest-numbered non-empty channel wins.
  always_comb begin
    vld_p0 = 1'b0;
    sel_p0 = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!vld_p0 && !empty[k]) begin
        vld_p0 = 1'b1;
        sel_p0 = CH_W'(k);
      end
    end
  end
`endif

  // Pop the selected FIFO head and evaluate it in the same cycle.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) pop[k] = vld_p0 && (sel_p0 == CH_W'(k));
    res_p0 = alu_eval(head_cmd[sel_p0], head_op1[sel_p0], head_op2[sel_p0]);
  end

  // ---- stage p0 -> p1: result register; resp pulses one cycle, data holds ----
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        resp_p1[k] <= RESP_NONE;
        data_p1[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        resp_p1[k] <= pop[k] ? res_p0.resp : RESP_NONE;
        if (pop[k]) data_p1[k] <= res_p0.data;
      end
    end
  end

endmodule

// File: doc/calc_ng.md
# calc_ng

Parametrised next-generation calculator core: NUM_CH independent request channels, DATA_W-bit operands, a per-channel request FIFO and one shared ALU behind an arbiter. Keeps the two-cycle request protocol and response codes of the existing calculator, adds configurable width and channel count, backpressure, and queued outstanding requests. Sits between the request drivers and the response collectors in the calculator subsystem.

## Interface
- NUM_CH, 4, number of request/response channels (1..8)
- DATA_W, 32, operand/result width (8..64, power of two)
- FIFO_DEPTH, 4, requests queued per channel (power of two, >=2)
- c_clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- req_cmd_in  in  NUM_CH*4  per-channel command, channel i at [4i+3:4i]
- req_data_in  in  NUM_CH*DATA_W  per-channel operand
- req_busy  out  NUM_CH  channel cannot accept a new command
- out_resp  out  NUM_CH*2  per-channel response: 0 none, 1 success, 2 error
- out_data  out  NUM_CH*DATA_W  per-channel result, valid only when out_resp!=0

## Operation
- Commands: 0 nop, 1 add, 2 sub, 5 shift-left, 6 shift-right; all other codes invalid.
- Per-channel capture FSM, states IDLE, OP2:
  - IDLE: cmd!=0 and req_busy=0 sampled -> latch cmd, op1=data; go OP2. cmd!=0 while busy -> dropped, no response.
  - OP2: latch op2=data, cmd field ignored; push {cmd,op1,op2} into channel FIFO; go IDLE.
- req_busy[i] = (count_i + (state_i==OP2)) >= FIFO_DEPTH, from registered state.
- Arbiter: each cycle selects one non-empty FIFO, pops it, ALU evaluates combinationally, result registered to that channel's outputs.
- ALU, DATA_W-bit unsigned:
  - add: carry out -> resp 2, data 0; else resp 1, op1+op2.
  - sub: op2>op1 -> resp 2, data 0; else resp 1, op1-op2.
  - shifts: amount = op2[log2(DATA_W)-1:0], zero fill, resp 1; upper op2 bits ignored.
  - invalid cmd: resp 2, data 0 (queued, answered in order like any request).
- Responses per channel return in request order.

## Timing
- Reset (reset=0): FSMs IDLE, FIFOs empty, arbiter pointer 0, req_busy all 0, out_resp all 0, out_data all 0; takes effect immediately, no clock needed.
- Reset mid-operation: all queued and half-captured requests discarded, no responses issued.
- Cmd sampled edge E0, op2 edge E1, entry pushed at E1; with idle arbiter, result registered at E2: out_resp/out_data driven from E2 to E3 (exactly one cycle), then out_resp returns to 0; out_data holds last value.
- Contention: one channel served per cycle; worst-case added latency NUM_CH-1 cycles per queued request ahead of it.
- Push and pop same FIFO same edge: count unchanged, both take effect.
- Back-to-back: new cmd accepted in cycle after OP2 (request every 2 cycles per channel).
- Busy asserts edge after reaching threshold; it deasserts the edge after the pop that frees space.

## Configuration
- CALC_NG_RR_ARB_EN defined: round-robin; pointer moves to channel after the one served; search starts at pointer.
- Undefined: fixed priority, channel 0 highest; lower channels may starve.

## Structure
- Package calc_ng_pkg: command code constants, response code constants (RESP_NONE=0, RESP_OK=1, RESP_ERR=2), request entry typedef {cmd, op1, op2}.
- Sub-module calc_ng_chan_fifo: one instance per channel, contains capture FSM, FIFO storage, count, busy.
- Arbiter and ALU in top level.

## Test plan
- Single add, ch0: 0x1 + 0x1FF_FFFF -> resp 1, data 0x200_0000 at E2; then 0xFFFF_FFFF + 1 -> resp 2, data 0.
- Sub underflow ch1: 1 - 0xF -> resp 2, data 0; 0xF - 1 -> resp 1, data 0xE; invalid cmd 3 -> resp 2, data 0.
- Shifts DATA_W=32: shl 1 by 31 -> 0x8000_0000; shr 0x8000_0000 by 33 -> 0x4000_0000 (amount 1), resp 1.
- All 4 channels add at same E0, RR enabled -> one response per cycle E2..E5 on ch0,1,2,3; without macro, same order, then repeated burst with ch0 refilling every 2 cycles never lets ch3 respond in overlap window.
- Backpressure FIFO_DEPTH=4, ALU blocked by higher-priority traffic: 4 requests accepted, req_busy high, 5th cmd dropped (no response); after drain exactly 4 responses in order.
- Reset asserted between E0 and E1 and with 3 queued entries -> all outputs 0 immediately, no responses after release; next request behaves as first.
